// File: rtl/caravel_gpio_bitbang_ctrl.sv
// caravel_gpio_bitbang_ctrl: SPI-programmed bit-bang / automatic loader for the GPIO pad-control serial chains.
module caravel_gpio_bitbang_ctrl #(
  parameter int CFG_BITS = 13,
  parameter int NUM_BLOCKS = 19,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 'h1809,
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic spi_csb,
  input  logic spi_sck,
  input  logic spi_sdi,
  output logic spi_sdo,
  output logic spi_sdo_oe,
  output logic serial_clock,
  output logic serial_load,
  output logic serial_resetn,
  output logic serial_data_1,
  output logic serial_data_2,
  output logic xfer_busy
);
  localparam int DW = $clog2(2*CLK_DIV+1);
  localparam int BW = $clog2(CFG_BITS);
  localparam int KW = $clog2(NUM_BLOCKS);
  typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA, P_IGN} phase_t;
  typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, CLK_LO, LOAD} state_t;
  logic [1:0] csb_s, sdi_s;
  logic [2:0] sck_s;
  logic csb, sdi, sck_rise, sck_fall;
  phase_t phase;
  logic rd_mode;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] addr, rd_sr, byte_in, rd_sel, rd_val;
  logic byte_done, wr_ctrl, start;
  logic [6:1] ctrl;
  logic bitbang;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [BW-1:0] bit_pos, bit_nx;
  logic [KW-1:0] blk, blk_nx;
  logic div_end, last_bit, fsm_data;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      csb_s <= 2'b11;
      sck_s <= '0;
      sdi_s <= '0;
    end else begin
      csb_s <= {csb_s[0], spi_csb};
      sck_s <= {sck_s[1:0], spi_sck};
      sdi_s <= {sdi_s[0], spi_sdi};
    end
  assign csb = csb_s[1];
  assign sdi = sdi_s[1];
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign byte_in = {sr, sdi};
  assign byte_done = ~csb & sck_rise & (bit_cnt == 3'd7);
  assign wr_ctrl = byte_done & (phase == P_DATA) & ~rd_mode & (addr == 8'h13);
  assign start = wr_ctrl & byte_in[0] & ~byte_in[1];
  assign bitbang = ctrl[1];
  // The first read byte comes from the address just received; later ones from the next address.
  assign rd_sel = (phase == P_ADDR) ? byte_in : addr + 8'd1;
  assign rd_val = (rd_sel == 8'h13) ? {1'b0, ctrl, xfer_busy} : 8'h00;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      phase <= P_CMD;
      rd_mode <= 1'b0;
      bit_cnt <= '0;
      sr <= '0;
      addr <= '0;
      rd_sr <= '0;
      spi_sdo <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else if (csb) begin
      phase <= P_CMD;
      bit_cnt <= '0;
      spi_sdo <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else begin
      if (sck_rise) begin
        sr <= byte_in[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (phase == P_CMD) begin
            rd_mode <= byte_in == 8'h40;
            phase <= (byte_in == 8'h80 || byte_in == 8'h40) ? P_ADDR : P_IGN;
          end else if (phase == P_ADDR) begin
            addr <= byte_in;
            phase <= P_DATA;
            rd_sr <= rd_val;
          end else if (phase == P_DATA) begin
            addr <= addr + 8'd1;
            rd_sr <= rd_val;
          end
        end
      end
      if (sck_fall && phase == P_DATA && rd_mode) begin
        spi_sdo <= rd_sr[7];
        rd_sr <= {rd_sr[6:0], 1'b0};
        spi_sdo_oe <= 1'b1;
      end
    end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) ctrl <= '0;
    else if (wr_ctrl) ctrl <= byte_in[6:1];
  assign div_end = div_cnt == ((state == LOAD) ? DW'(2*CLK_DIV-1) : DW'(CLK_DIV-1));
  assign last_bit = (bit_pos == '0) && (blk == KW'(NUM_BLOCKS-1));
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_pos <= '0;
      blk <= '0;
    end else begin
      state <= state_nx;
      div_cnt <= div_nx;
      bit_pos <= bit_nx;
      blk <= blk_nx;
    end
  always_comb begin
    state_nx = state;
    div_nx = div_end ? '0 : div_cnt + 1'b1;
    bit_nx = bit_pos;
    blk_nx = blk;
    if (state == IDLE) begin
      div_nx = '0;
      if (start) begin
        state_nx = SETUP;
        bit_nx = BW'(CFG_BITS-1);
        blk_nx = '0;
      end
    end else if (bitbang) begin
      state_nx = IDLE;
      div_nx = '0;
    end else if (div_end) begin
      if (state == SETUP || state == CLK_LO) state_nx = CLK_HI;
      else if (state == LOAD) state_nx = IDLE;
      else if (last_bit) state_nx = LOAD;
      else begin
        state_nx = CLK_LO;
        bit_nx = (bit_pos == '0) ? BW'(CFG_BITS-1) : bit_pos - 1'b1;
        blk_nx = (bit_pos == '0) ? blk + 1'b1 : blk;
      end
    end
  end
  assign fsm_data = (state == SETUP || state == CLK_HI || state == CLK_LO) & DEFAULT_CFG[bit_pos];
  assign xfer_busy = state != IDLE;
  always_comb begin
    serial_resetn = bitbang ? ctrl[2] : 1'b1;
    serial_load = bitbang ? ctrl[3] : state == LOAD;
    serial_clock = bitbang ? ctrl[4] : state == CLK_HI;
    serial_data_1 = bitbang ? ctrl[5] : fsm_data;
    serial_data_2 = bitbang ? ctrl[6] : fsm_data;
  end
endmodule

// File: tb/tb_caravel_gpio_bitbang_ctrl.sv
// tb_caravel_gpio_bitbang_ctrl: directed SPI bit-bang, readback and automatic-transfer checks.
`timescale 1ns/1ps
module tb_caravel_gpio_bitbang_ctrl;
  localparam int HALF = 80;
  logic clock = 0, resetb = 0, spi_csb = 1, spi_sck = 0, spi_sdi = 0;
  logic spi_sdo, spi_sdo_oe, serial_clock, serial_load, serial_resetn;
  logic serial_data_1, serial_data_2, xfer_busy;
  int tests = 0, fails = 0;
  logic mon_clr = 1;
  int rises, loads, load_len, last_load_len, load_clk_err;
  logic s1 [0:511];
  logic s2 [0:511];
  logic sclk_q = 0, load_q = 0;
  caravel_gpio_bitbang_ctrl dut (
    .clock(clock), .resetb(resetb), .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .serial_clock(serial_clock), .serial_load(serial_load),
    .serial_resetn(serial_resetn), .serial_data_1(serial_data_1), .serial_data_2(serial_data_2),
    .xfer_busy(xfer_busy)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (mon_clr) begin
      rises = 0;
      loads = 0;
      load_len = 0;
      last_load_len = 0;
      load_clk_err = 0;
    end else begin
      if (serial_clock && !sclk_q) begin
        if (rises < 512) begin
          s1[rises] = serial_data_1;
          s2[rises] = serial_data_2;
        end
        rises++;
      end
      if (serial_load) begin
        load_len++;
        if (serial_clock) load_clk_err++;
      end else if (load_q) begin
        loads++;
        last_load_len = load_len;
        load_len = 0;
      end
    end
    sclk_q = serial_clock;
    load_q = serial_load;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_all, output logic oe_any);
    oe_all = 1;
    oe_any = 0;
    for (int i = 7; i >= 0; i--) begin
      spi_sdi = tx[i];
      #(HALF);
      rx[i] = spi_sdo;
      oe_all &= spi_sdo_oe;
      oe_any |= spi_sdo_oe;
      spi_sck = 1;
      #(HALF);
      spi_sck = 0;
    end
  endtask
  task automatic spi_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic hdr_oe, output logic dat_oe);
    logic [7:0] r;
    logic x, y;
    @(negedge clock);
    spi_csb = 0;
    #(HALF);
    spi_byte(c, r, x, y);
    hdr_oe = y;
    spi_byte(a, r, x, y);
    hdr_oe |= y;
    spi_byte(d, rd, dat_oe, y);
    #(HALF);
    spi_csb = 1;
    #(HALF);
  endtask
  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic x, y;
    spi_frame(8'h80, a, d, r, x, y);
  endtask
  task automatic wait_idle(output logic ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (!xfer_busy) begin
        ok = 1;
        break;
      end
    end
  endtask
  task automatic check_outs(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {serial_resetn, serial_load, serial_clock, serial_data_1, serial_data_2};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: outputs {resetn,load,clock,d1,d2} got %b expected %b", name, got, exp);
    end
  endtask
  task automatic check_stream(input string name);
    logic [12:0] cfg;
    int errs;
    cfg = 13'h1809;
    errs = 0;
    for (int k = 0; k < 247; k++)
      if (s1[k] !== cfg[12 - (k % 13)] || s2[k] !== cfg[12 - (k % 13)]) errs++;
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s: %0d stream bits wrong, expected 0 wrong", name, errs);
    end
  endtask
  task automatic test_reset();
    resetb = 0;
    tick(3);
    @(negedge clock);
    resetb = 1;
    tick(100);
    @(negedge clock);
    check_outs("reset_outs", 5'b10000);
    tests++;
    if ({xfer_busy, spi_sdo, spi_sdo_oe} !== 3'b000) begin
      fails++;
      $display("FAIL reset_misc: {busy,sdo,oe} got %b expected 000", {xfer_busy, spi_sdo, spi_sdo_oe});
    end
  endtask
  task automatic test_bitbang();
    spi_write(8'h13, 8'h66);
    tick(4);
    @(negedge clock);
    check_outs("bb_66", 5'b10011);
    spi_write(8'h13, 8'h76);
    tick(4);
    @(negedge clock);
    check_outs("bb_76", 5'b10111);
    spi_write(8'h13, 8'h06);
    tick(4);
    @(negedge clock);
    check_outs("bb_06", 5'b10000);
  endtask
  task automatic test_read();
    logic [7:0] rd;
    logic h, d;
    spi_write(8'h13, 8'h56);
    spi_frame(8'h40, 8'h13, 8'h00, rd, h, d);
    tests++;
    if (rd !== 8'h56) begin
      fails++;
      $display("FAIL read_13: got %h expected 56", rd);
    end
    tests++;
    if (h !== 1'b0 || d !== 1'b1) begin
      fails++;
      $display("FAIL read_oe: hdr_oe %b data_oe %b expected 0 1", h, d);
    end
    tests++;
    if (spi_sdo_oe !== 1'b0) begin
      fails++;
      $display("FAIL read_oe_end: got %b expected 0", spi_sdo_oe);
    end
    spi_frame(8'h40, 8'h12, 8'h00, rd, h, d);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL read_12: got %h expected 00", rd);
    end
    spi_write(8'h13, 8'h00);
  endtask
  task automatic run_xfer(input string name, input logic second_write);
    logic ok;
    mon_clr = 1;
    tick(2);
    mon_clr = 0;
    spi_write(8'h13, 8'h01);
    tests++;
    if (xfer_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: got %b expected 1", name, xfer_busy);
    end
    if (second_write) spi_write(8'h13, 8'h01);
    wait_idle(ok);
    tick(3);
    tests++;
    if (!ok || rises != 247) begin
      fails++;
      $display("FAIL %s_rises: done %b rises %0d expected 247", name, ok, rises);
    end
    check_stream({name, "_stream"});
    tests++;
    if (loads != 1 || last_load_len != 4 || load_clk_err != 0) begin
      fails++;
      $display("FAIL %s_load: pulses %0d len %0d clk_err %0d expected 1 4 0", name, loads, last_load_len, load_clk_err);
    end
    @(negedge clock);
    check_outs({name, "_idle"}, 5'b10000);
  endtask
  task automatic test_xfer();
    run_xfer("xfer", 1'b1);
  endtask
  task automatic test_abort();
    spi_write(8'h13, 8'h01);
    tick(100);
    spi_write(8'h13, 8'h02);
    @(negedge clock);
    tests++;
    if (xfer_busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: got %b expected 0", xfer_busy);
    end
    check_outs("abort_bb", 5'b00000);
    spi_write(8'h13, 8'h00);
    tick(2);
    @(negedge clock);
    check_outs("abort_release", 5'b10000);
  endtask
  task automatic test_reset_mid();
    mon_clr = 1;
    tick(2);
    mon_clr = 0;
    spi_write(8'h13, 8'h01);
    tick(50);
    @(negedge clock);
    resetb = 0;
    #1;
    check_outs("rst_mid_outs", 5'b10000);
    tests++;
    if (xfer_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_busy: got %b expected 0", xfer_busy);
    end
    tick(5);
    @(negedge clock);
    resetb = 1;
    tick(1500);
    tests++;
    if (loads != 0 || xfer_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_noload: pulses %0d busy %b expected 0 0", loads, xfer_busy);
    end
    run_xfer("rst_fresh", 1'b0);
  endtask
  task automatic test_ignored();
    logic [7:0] rd;
    logic h, d;
    spi_write(8'h13, 8'h56);
    spi_write(8'h14, 8'hFF);
    spi_frame(8'h20, 8'h13, 8'hFF, rd, h, d);
    tick(4);
    @(negedge clock);
    check_outs("ign_outs", 5'b10101);
    spi_frame(8'h40, 8'h13, 8'h00, rd, h, d);
    tests++;
    if (rd !== 8'h56) begin
      fails++;
      $display("FAIL ign_reg: got %h expected 56", rd);
    end
  endtask
  initial begin
    test_reset();
    test_bitbang();
    test_read();
    test_xfer();
    test_abort();
    test_reset_mid();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
